// File: rtl/id_stage.sv
// Instruction decode: operand fetch with EX/MEM forwarding, load-use detection, branch resolution.
// Latency: read enables, stall and redirect are combinational; ID/EX fields are registered (1 cycle).
// Backpressure: a load-use hazard raises stall_req for one cycle and loads a bubble into ID/EX.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic        en_rs,
    output logic        en_rt,
    output logic [4:0]  raddr1,
    output logic [4:0]  raddr2,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic        ex_fwd_wif,
    input  logic [4:0]  ex_fwd_waddr,
    input  logic [31:0] ex_fwd_wdata,
    input  logic        ex_fwd_load,
    input  logic        mem_fwd_wif,
    input  logic [4:0]  mem_fwd_waddr,
    input  logic [31:0] mem_fwd_wdata,
    output logic        stall_req,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        id_ex_valid,
    output logic [3:0]  id_ex_aluop,
    output logic [31:0] id_ex_opa,
    output logic [31:0] id_ex_opb,
    output logic        id_ex_wif,
    output logic [4:0]  id_ex_waddr,
    output logic        id_ex_load,
    output logic        id_ex_store,
    output logic [31:0] id_ex_sdata
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;

    // Destination select
    localparam logic [1:0] WSEL_NONE = 2'd0;
    localparam logic [1:0] WSEL_RD   = 2'd1;
    localparam logic [1:0] WSEL_RT   = 2'd2;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [15:0] w_imm;
    assign w_op    = if_inst[31:26];
    assign w_rs    = if_inst[25:21];
    assign w_rt    = if_inst[20:16];
    assign w_rd    = if_inst[15:11];
    assign w_shamt = if_inst[10:6];
    assign w_funct = if_inst[5:0];
    assign w_imm   = if_inst[15:0];

    // An instruction is only acted on out of reset and when IF/ID is valid
    logic w_act;
    assign w_act = rst & if_valid;

    logic       w_use_rs;
    logic       w_use_rt;
    logic [3:0] w_aluop;
    logic [1:0] w_wsel;
    logic       w_load;
    logic       w_store;
    logic       w_beq;
    logic       w_bne;
    logic       w_j;
    logic       w_shift;
    logic       w_lui;
    logic       w_sext;
    logic       w_zext;

    // Opcode/funct decode; unknown encodings fall through as a NOP with no side effects
    always_comb begin
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_aluop  = ALU_ADD;
        w_wsel   = WSEL_NONE;
        w_load   = 1'b0;
        w_store  = 1'b0;
        w_beq    = 1'b0;
        w_bne    = 1'b0;
        w_j      = 1'b0;
        w_shift  = 1'b0;
        w_lui    = 1'b0;
        w_sext   = 1'b0;
        w_zext   = 1'b0;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h21: begin w_aluop = ALU_ADD; w_use_rs = 1'b1; w_use_rt = 1'b1; w_wsel = WSEL_RD; end
                    6'h23: begin w_aluop = ALU_SUB; w_use_rs = 1'b1; w_use_rt = 1'b1; w_wsel = WSEL_RD; end
                    6'h24: begin w_aluop = ALU_AND; w_use_rs = 1'b1; w_use_rt = 1'b1; w_wsel = WSEL_RD; end
                    6'h25: begin w_aluop = ALU_OR;  w_use_rs = 1'b1; w_use_rt = 1'b1; w_wsel = WSEL_RD; end
                    6'h26: begin w_aluop = ALU_XOR; w_use_rs = 1'b1; w_use_rt = 1'b1; w_wsel = WSEL_RD; end
                    6'h27: begin w_aluop = ALU_NOR; w_use_rs = 1'b1; w_use_rt = 1'b1; w_wsel = WSEL_RD; end
                    6'h2A: begin w_aluop = ALU_SLT; w_use_rs = 1'b1; w_use_rt = 1'b1; w_wsel = WSEL_RD; end
                    6'h00: begin w_aluop = ALU_SLL; w_use_rt = 1'b1; w_shift = 1'b1; w_wsel = WSEL_RD; end
                    6'h02: begin w_aluop = ALU_SRL; w_use_rt = 1'b1; w_shift = 1'b1; w_wsel = WSEL_RD; end
                    default: ;
                endcase
            end
            6'h09: begin w_aluop = ALU_ADD; w_use_rs = 1'b1; w_sext = 1'b1; w_wsel = WSEL_RT; end
            6'h0A: begin w_aluop = ALU_SLT; w_use_rs = 1'b1; w_sext = 1'b1; w_wsel = WSEL_RT; end
            6'h0C: begin w_aluop = ALU_AND; w_use_rs = 1'b1; w_zext = 1'b1; w_wsel = WSEL_RT; end
            6'h0D: begin w_aluop = ALU_OR;  w_use_rs = 1'b1; w_zext = 1'b1; w_wsel = WSEL_RT; end
            6'h0E: begin w_aluop = ALU_XOR; w_use_rs = 1'b1; w_zext = 1'b1; w_wsel = WSEL_RT; end
            6'h0F: begin w_aluop = ALU_LUI; w_lui = 1'b1; w_wsel = WSEL_RT; end
            6'h23: begin w_aluop = ALU_ADD; w_use_rs = 1'b1; w_sext = 1'b1; w_load = 1'b1; w_wsel = WSEL_RT; end
            6'h2B: begin w_aluop = ALU_ADD; w_use_rs = 1'b1; w_use_rt = 1'b1; w_sext = 1'b1; w_store = 1'b1; end
            6'h04: begin w_aluop = ALU_SUB; w_use_rs = 1'b1; w_use_rt = 1'b1; w_beq = 1'b1; end
            6'h05: begin w_aluop = ALU_SUB; w_use_rs = 1'b1; w_use_rt = 1'b1; w_bne = 1'b1; end
            6'h02: begin w_j = 1'b1; end
            default: ;
        endcase
    end

    assign en_rs  = w_act & w_use_rs;
    assign en_rt  = w_act & w_use_rt;
    assign raddr1 = rst ? w_rs : 5'd0;
    assign raddr2 = rst ? w_rt : 5'd0;

    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

    // Operand selection: $0/disabled reads give 0, then EX beats MEM beats the register file
    always_comb begin
        w_rs_val = rdata1;
        if (!en_rs || w_rs == 5'd0)
            w_rs_val = 32'd0;
        else if (ex_fwd_wif && ex_fwd_waddr == w_rs)
            w_rs_val = ex_fwd_wdata;
        else if (mem_fwd_wif && mem_fwd_waddr == w_rs)
            w_rs_val = mem_fwd_wdata;

        w_rt_val = rdata2;
        if (!en_rt || w_rt == 5'd0)
            w_rt_val = 32'd0;
        else if (ex_fwd_wif && ex_fwd_waddr == w_rt)
            w_rt_val = ex_fwd_wdata;
        else if (mem_fwd_wif && mem_fwd_waddr == w_rt)
            w_rt_val = mem_fwd_wdata;
    end

    // A load in EX cannot forward yet; hold the consumer one cycle so it picks the value up from MEM
    assign stall_req = w_act & ex_fwd_load & ex_fwd_wif & (ex_fwd_waddr != 5'd0) &
                       ((en_rs & (ex_fwd_waddr == w_rs)) | (en_rt & (ex_fwd_waddr == w_rt)));

    logic [31:0] w_pc4;
    logic [31:0] w_btarget;
    logic [31:0] w_jtarget;
    logic        w_eq;
    assign w_pc4     = if_pc + 32'd4;
    assign w_btarget = w_pc4 + {{14{w_imm[15]}}, w_imm, 2'b00};
    assign w_jtarget = {w_pc4[31:28], if_inst[25:0], 2'b00};
    assign w_eq      = (w_rs_val == w_rt_val);

    assign branch_taken  = w_act & ~stall_req & ((w_beq & w_eq) | (w_bne & ~w_eq) | w_j);
    assign branch_target = !rst ? 32'd0 : (w_j ? w_jtarget : w_btarget);

    logic [31:0] w_opa;
    logic [31:0] w_opb;
    logic [4:0]  w_dest;
    logic        w_wif;

    // Operand A/B shaping for immediates and shifts
    always_comb begin
        w_opa = w_rs_val;
        w_opb = w_rt_val;
        if (w_lui) begin
            w_opa = 32'd0;
            w_opb = {w_imm, 16'h0000};
        end else if (w_shift) begin
            w_opa = w_rt_val;
            w_opb = {27'd0, w_shamt};
        end else if (w_sext) begin
            w_opb = {{16{w_imm[15]}}, w_imm};
        end else if (w_zext) begin
            w_opb = {16'h0000, w_imm};
        end
    end

    assign w_dest = (w_wsel == WSEL_RD) ? w_rd : ((w_wsel == WSEL_RT) ? w_rt : 5'd0);
    assign w_wif  = (w_wsel != WSEL_NONE) && (w_dest != 5'd0);

    logic        r_valid;
    logic [3:0]  r_aluop;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic        r_wif;
    logic [4:0]  r_waddr;
    logic        r_load;
    logic        r_store;
    logic [31:0] r_sdata;

    // ID/EX register: loads the decoded instruction, or an all-zero bubble when idle or stalled
    always_ff @(posedge clk) begin
        if (!rst || !w_act || stall_req) begin
            r_valid <= 1'b0;
            r_aluop <= 4'd0;
            r_opa   <= 32'd0;
            r_opb   <= 32'd0;
            r_wif   <= 1'b0;
            r_waddr <= 5'd0;
            r_load  <= 1'b0;
            r_store <= 1'b0;
            r_sdata <= 32'd0;
        end else begin
            r_valid <= 1'b1;
            r_aluop <= w_aluop;
            r_opa   <= w_opa;
            r_opb   <= w_opb;
            r_wif   <= w_wif;
            r_waddr <= w_dest;
            r_load  <= w_load;
            r_store <= w_store;
            r_sdata <= w_store ? w_rt_val : 32'd0;
        end
    end

    assign id_ex_valid = r_valid;
    assign id_ex_aluop = r_aluop;
    assign id_ex_opa   = r_opa;
    assign id_ex_opb   = r_opb;
    assign id_ex_wif   = r_wif;
    assign id_ex_waddr = r_waddr;
    assign id_ex_load  = r_load;
    assign id_ex_store = r_store;
    assign id_ex_sdata = r_sdata;

endmodule
